// File: rtl/reg_file_param.sv
// reg_file_param: parameterised register file with two combinational read
// ports, one synchronous write port, optional write-to-read forwarding,
// optional hardwired-zero register 0 and a sequential clear sweep.
//
// Ports:
//   clock           - single clock, all state changes on rising edge
//   reset           - asynchronous, active-low reset
//   regWrite        - write enable
//   write_reg_addr  - write destination address
//   write_data      - write value
//   read_reg_addr_1 - read port 1 address
//   read_reg_addr_2 - read port 2 address
//   clear_req       - request a sequential clear of all registers
//   read_data_1     - read port 1 data (combinational)
//   read_data_2     - read port 2 data (combinational)
//   busy            - high while the clear sweep runs
//   clear_done      - one-cycle pulse in the first IDLE cycle after a sweep
//   write_drop      - one-cycle pulse after a write that was discarded
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] write_reg_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_addr_1,
  input  logic [ADDR_W-1:0] read_reg_addr_2,
  input  logic              clear_req,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              busy,
  output logic              clear_done,
  output logic              write_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              last;
  logic              wr_en;
  logic              wr_discard;
  logic              wr_zero_reg;

  // Writes to a hardwired register 0 are silently ignored: neither stored
  // nor reported as dropped.
  assign wr_zero_reg = (ZERO_REG != 0) && (write_reg_addr == '0);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    wr_en      = 1'b0;
    wr_discard = 1'b0;
    // Exit is decided on the last index before incrementing, so idx never wraps.
    last       = (idx == ADDR_W'(DEPTH - 1));
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_nxt  = CLEAR;
          idx_nxt    = '0;
          wr_discard = regWrite;
        end else begin
          wr_en = regWrite;
        end
      end
      CLEAR: begin
        wr_discard = regWrite;
        if (last) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
    endcase
    if (wr_zero_reg) begin
      wr_en      = 1'b0;
      wr_discard = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      clear_done <= 1'b0;
      write_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      clear_done <= (state == CLEAR) && last;
      write_drop <= wr_discard;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
    end else if (wr_en) begin
      regs[write_reg_addr] <= write_data;
    end
  end

  assign busy = (state == CLEAR);

  // Forwarding follows the write request in IDLE; zero-register masking
  // is applied last so it also overrides forwarded data.
  always_comb begin
    read_data_1 = regs[read_reg_addr_1];
    if ((BYPASS != 0) && (state == IDLE) && regWrite &&
        (read_reg_addr_1 == write_reg_addr)) begin
      read_data_1 = write_data;
    end
    if ((ZERO_REG != 0) && (read_reg_addr_1 == '0)) begin
      read_data_1 = '0;
    end
  end

  always_comb begin
    read_data_2 = regs[read_reg_addr_2];
    if ((BYPASS != 0) && (state == IDLE) && regWrite &&
        (read_reg_addr_2 == write_reg_addr)) begin
      read_data_2 = write_data;
    end
    if ((ZERO_REG != 0) && (read_reg_addr_2 == '0)) begin
      read_data_2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: drives three reg_file_param variants (defaults,
// no forwarding, hardwired zero register) with shared stimulus and checks
// them against a behavioural model of the register file and clear sweep.
module tb_reg_file_param;

  logic        clock;
  logic        reset;
  logic        regWrite;
  logic [3:0]  write_reg_addr;
  logic [15:0] write_data;
  logic [3:0]  read_reg_addr_1;
  logic [3:0]  read_reg_addr_2;
  logic        clear_req;

  logic [15:0] rd1_def, rd2_def, rd1_nb, rd2_nb, rd1_z, rd2_z;
  logic        busy_def, busy_nb, busy_z;
  logic        done_def, done_nb, done_z;
  logic        drop_def, drop_nb, drop_z;

  reg_file_param u_def (
    .clock(clock), .reset(reset), .regWrite(regWrite),
    .write_reg_addr(write_reg_addr), .write_data(write_data),
    .read_reg_addr_1(read_reg_addr_1), .read_reg_addr_2(read_reg_addr_2),
    .clear_req(clear_req), .read_data_1(rd1_def), .read_data_2(rd2_def),
    .busy(busy_def), .clear_done(done_def), .write_drop(drop_def)
  );

  reg_file_param #(.BYPASS(0)) u_nb (
    .clock(clock), .reset(reset), .regWrite(regWrite),
    .write_reg_addr(write_reg_addr), .write_data(write_data),
    .read_reg_addr_1(read_reg_addr_1), .read_reg_addr_2(read_reg_addr_2),
    .clear_req(clear_req), .read_data_1(rd1_nb), .read_data_2(rd2_nb),
    .busy(busy_nb), .clear_done(done_nb), .write_drop(drop_nb)
  );

  reg_file_param #(.ZERO_REG(1)) u_z (
    .clock(clock), .reset(reset), .regWrite(regWrite),
    .write_reg_addr(write_reg_addr), .write_data(write_data),
    .read_reg_addr_1(read_reg_addr_1), .read_reg_addr_2(read_reg_addr_2),
    .clear_req(clear_req), .read_data_1(rd1_z), .read_data_2(rd2_z),
    .busy(busy_z), .clear_done(done_z), .write_drop(drop_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem [16];
  bit          sweeping;
  int          pos;
  bit          done_e, drop_e, drop_ze;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inst: 0 = defaults, 1 = no forwarding, 2 = zero register
  function automatic logic [15:0] exp_rd(input int inst, input logic [3:0] a);
    logic [15:0] v;
    v = mem[a];
    if (inst != 1 && !sweeping && regWrite === 1'b1 && a == write_reg_addr) v = write_data;
    if (inst == 2 && a == 4'd0) v = 16'h0000;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    sweeping = 1'b0;
    pos      = 0;
    done_e   = 1'b0;
    drop_e   = 1'b0;
    drop_ze  = 1'b0;
  endtask

  task automatic model_edge();
    if (!sweeping) begin
      done_e = 1'b0;
      if (clear_req) begin
        sweeping = 1'b1;
        pos      = 0;
        drop_e   = regWrite;
        drop_ze  = regWrite && (write_reg_addr != 4'd0);
      end else begin
        drop_e  = 1'b0;
        drop_ze = 1'b0;
        if (regWrite) mem[write_reg_addr] = write_data;
      end
    end else begin
      mem[pos] = 16'h0000;
      drop_e   = regWrite;
      drop_ze  = regWrite && (write_reg_addr != 4'd0);
      done_e   = (pos == 15);
      pos++;
      if (pos == 16) sweeping = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":rd1_def"}, rd1_def, exp_rd(0, read_reg_addr_1));
    chk({tag, ":rd2_def"}, rd2_def, exp_rd(0, read_reg_addr_2));
    chk({tag, ":rd1_nb"},  rd1_nb,  exp_rd(1, read_reg_addr_1));
    chk({tag, ":rd2_nb"},  rd2_nb,  exp_rd(1, read_reg_addr_2));
    chk({tag, ":rd1_z"},   rd1_z,   exp_rd(2, read_reg_addr_1));
    chk({tag, ":rd2_z"},   rd2_z,   exp_rd(2, read_reg_addr_2));
    chk({tag, ":busy_def"}, {15'd0, busy_def}, {15'd0, sweeping});
    chk({tag, ":busy_nb"},  {15'd0, busy_nb},  {15'd0, sweeping});
    chk({tag, ":busy_z"},   {15'd0, busy_z},   {15'd0, sweeping});
    chk({tag, ":done_def"}, {15'd0, done_def}, {15'd0, done_e});
    chk({tag, ":done_nb"},  {15'd0, done_nb},  {15'd0, done_e});
    chk({tag, ":done_z"},   {15'd0, done_z},   {15'd0, done_e});
    chk({tag, ":drop_def"}, {15'd0, drop_def}, {15'd0, drop_e});
    chk({tag, ":drop_nb"},  {15'd0, drop_nb},  {15'd0, drop_e});
    chk({tag, ":drop_z"},   {15'd0, drop_z},   {15'd0, drop_ze});
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    if (reset) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    regWrite  = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    tick("in_reset");
    reset = 1'b1;
    #1;
  endtask

  int cnt;
  int drops;

  initial begin
    reset           = 1'b0;
    regWrite        = 1'b0;
    write_reg_addr  = 4'd0;
    write_data      = 16'h0000;
    read_reg_addr_1 = 4'd3;
    read_reg_addr_2 = 4'd5;
    clear_req       = 1'b0;
    model_reset();

    // Reset state and basic write/read
    do_reset();
    regWrite = 1'b1; write_reg_addr = 4'd3; write_data = 16'h1234; read_reg_addr_1 = 4'd3;
    tick("wr_r3");
    regWrite = 1'b0;
    #1;
    check_all("rd_r3");
    chk("r3_direct", rd1_def, 16'h1234);

    // Forwarding vs no forwarding
    regWrite = 1'b1; write_reg_addr = 4'd5; write_data = 16'hBEEF; read_reg_addr_2 = 4'd5;
    #1;
    check_all("bypass");
    chk("bypass_def", rd2_def, 16'hBEEF);
    chk("bypass_nb_old", rd2_nb, 16'h0000);
    tick("bypass_wr");

    // Zero register
    write_reg_addr = 4'd0; write_data = 16'hFFFF; read_reg_addr_1 = 4'd0; read_reg_addr_2 = 4'd0;
    #1;
    check_all("zero_byp");
    tick("zero_wr");
    regWrite = 1'b0;
    #1;
    check_all("zero_rd");
    chk("zero_rd1", rd1_z, 16'h0000);
    chk("zero_rd2", rd2_z, 16'h0000);
    chk("zero_nodrop", {15'd0, drop_z}, 16'h0000);

    // Full sweep
    for (int i = 0; i < 16; i++) begin
      regWrite = 1'b1; write_reg_addr = 4'(i); write_data = 16'h0100 + 16'(i);
      tick("load");
    end
    regWrite = 1'b0; clear_req = 1'b1;
    tick("clr_start");
    clear_req = 1'b0;
    cnt = 0;
    while (busy_def === 1'b1 && cnt < 40) begin
      cnt++;
      read_reg_addr_1 = 4'(cnt); read_reg_addr_2 = 4'(cnt - 1);
      tick("sweep");
    end
    chk("busy_cycles", 16'(cnt), 16'd16);
    chk("done_pulse", {15'd0, done_def}, 16'h0001);
    tick("after_done");
    chk("done_cleared", {15'd0, done_def}, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      read_reg_addr_1 = 4'(i); read_reg_addr_2 = 4'(15 - i);
      #1;
      check_all("cleared");
    end

    // Writes discarded at clear request and mid-sweep
    drops = 0;
    regWrite = 1'b1; write_reg_addr = 4'd7; write_data = 16'hAAAA; clear_req = 1'b1;
    read_reg_addr_1 = 4'd7;
    tick("drop_req");
    if (drop_def === 1'b1) drops++;
    clear_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      regWrite = (i == 10);
      tick("drop_sweep");
      if (drop_def === 1'b1) drops++;
    end
    regWrite = 1'b0;
    tick("drop_end");
    if (drop_def === 1'b1) drops++;
    chk("drop_count", 16'(drops), 16'd2);
    chk("r7_zero", rd1_def, 16'h0000);

    // Reset mid-sweep
    for (int i = 0; i < 16; i++) begin
      regWrite = 1'b1; write_reg_addr = 4'(i); write_data = 16'h5A00 + 16'(i);
      tick("reload");
    end
    regWrite = 1'b0; clear_req = 1'b1;
    tick("clr2_start");
    clear_req = 1'b0;
    for (int i = 0; i < 6; i++) tick("clr2_sweep");
    read_reg_addr_1 = 4'd12; read_reg_addr_2 = 4'd3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    chk("mid_reset_busy", {15'd0, busy_def}, 16'h0000);
    chk("mid_reset_rd", rd1_def, 16'h0000);
    tick("mid_reset_hold");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      tick("post_reset");
      chk("no_done", {15'd0, done_def}, 16'h0000);
    end
    regWrite = 1'b1; write_reg_addr = 4'd12; write_data = 16'h4321;
    tick("post_wr");
    regWrite = 1'b0;
    #1;
    check_all("post_rd");
    chk("post_wr_direct", rd1_def, 16'h4321);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      regWrite        = 1'($urandom_range(0, 1));
      write_reg_addr  = 4'($urandom_range(0, 15));
      write_data      = 16'($urandom);
      read_reg_addr_1 = 4'($urandom_range(0, 15));
      read_reg_addr_2 = 4'($urandom_range(0, 15));
      clear_req       = ($urandom_range(0, 24) == 0);
      #1;
      check_all("rnd_comb");
      tick("rnd_edge");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, giving the address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding enabled.
REQ-004 The block SHALL have parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-005 The block SHALL have the port clock  in  1  -- single clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port reset  in  1  -- asynchronous, active-low reset.
REQ-007 The block SHALL have the port regWrite  in  1  -- write enable.
REQ-008 The block SHALL have the port write_reg_addr  in  ADDR_W  -- write destination.
REQ-009 The block SHALL have the port write_data  in  DATA_W  -- write value.
REQ-010 The block SHALL have the port read_reg_addr_1  in  ADDR_W  -- read port 1 address.
REQ-011 The block SHALL have the port read_reg_addr_2  in  ADDR_W  -- read port 2 address.
REQ-012 The block SHALL have the port clear_req  in  1  -- request a sequential clear of all registers.
REQ-013 The block SHALL have the port read_data_1  out  DATA_W  -- read port 1 data.
REQ-014 The block SHALL have the port read_data_2  out  DATA_W  -- read port 2 data.
REQ-015 The block SHALL have the port busy  out  1  -- high while the clear sweep runs.
REQ-016 The block SHALL have the port clear_done  out  1  -- one-cycle pulse at the end of the sweep.
REQ-017 The block SHALL have the port write_drop  out  1  -- one-cycle pulse when a requested write was discarded.

Function
REQ-018 Writes SHALL be synchronous: in IDLE with regWrite=1, register[write_reg_addr] takes write_data at the rising clock edge.
REQ-019 Reads SHALL be combinational from the array, with zero cycles of latency.
REQ-020 With BYPASS=1, in IDLE with regWrite=1 and a read address equal to write_reg_addr, that read port SHALL output write_data in the same cycle.
REQ-021 With ZERO_REG=1, address 0 SHALL always read 0 on both ports, bypass included; writes to address 0 SHALL be ignored without a write_drop pulse.
REQ-022 The FSM SHALL have states IDLE and CLEAR and an internal sweep index idx of width ADDR_W.
REQ-023 IDLE→CLEAR SHALL occur on a rising edge with clear_req=1; idx is loaded with 0 and no register is cleared on that edge.
REQ-024 In CLEAR, each rising edge SHALL zero register[idx] and increment idx.
REQ-025 After clearing idx=DEPTH-1, the FSM SHALL return to IDLE.
REQ-026 A full sweep SHALL take exactly DEPTH cycles in CLEAR.
REQ-027 busy SHALL be 1 exactly while the state is CLEAR.
REQ-028 clear_done SHALL be 1 for the single cycle after the edge that clears DEPTH-1, i.e. the first IDLE cycle.
REQ-029 Any write requested in CLEAR, or in IDLE in the same cycle as clear_req=1, SHALL be discarded.
REQ-030 For each discarded write, write_drop SHALL be 1 in the next cycle (registered, one cycle per dropped write).
REQ-031 clear_req SHALL be ignored while in CLEAR; the sweep is not restarted.
REQ-032 Reads during CLEAR SHALL return current array contents, which are partially cleared, and bypass SHALL be inactive.
REQ-033 idx wrap SHALL not occur: the CLEAR exit is decided on idx=DEPTH-1 before the increment.

Reset
REQ-034 On reset=0, immediately and independent of clock, all registers SHALL go to 0.
REQ-035 On reset=0, the state SHALL go to IDLE, idx to 0, and busy, clear_done and write_drop to 0.
REQ-036 On reset=0, read_data_1 and read_data_2 SHALL consequently read 0.
REQ-037 Reset asserted mid-sweep SHALL abort the sweep with no clear_done pulse.
REQ-038 After reset release, the first rising edge SHALL accept writes or clear_req normally.

Verification
REQ-039 Defaults; reset low then high; write 0x1234→r3; set read_reg_addr_1=3 -> read_data_1=0x1234 after the edge; before reset release all reads are 0.
REQ-040 BYPASS=1; regWrite=1, addr 5, data 0xBEEF; read_reg_addr_2=5 in the same cycle -> read_data_2=0xBEEF before the edge; with BYPASS=0 -> old value 0x0000.
REQ-041 ZERO_REG=1; write 0xFFFF→r0 -> r0 reads 0x0000 on both ports and write_drop stays 0.
REQ-042 Load r0..r15 with 0x0100+i; pulse clear_req -> busy high for exactly 16 cycles, r0..r15 read 0, clear_done high one cycle, busy low.
REQ-043 Write addr 7 data 0xAAAA in the same cycle as clear_req, then again at sweep cycle 10 -> both writes discarded, r7=0 at end, write_drop pulses twice.
REQ-044 Start sweep; assert reset at sweep cycle 6 -> busy=0 immediately, all reads 0, no clear_done; a write after release succeeds.
